// File: rtl/music_sequencer.sv
// Song tone-table sequencer: steps quarter-beat indices at a fixed tempo under
// play/pause/stop/loop control and turns the returned tone (Hz) into a square wave.
module music_sequencer #(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned BEAT_HZ   = 8,
    parameter int unsigned SONG_LEN  = 118,
    parameter int unsigned MUTE_TONE = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        pause,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [31:0] tone_in,
    output logic [7:0]  beat_num,
    output logic [1:0]  state,
    output logic        playing,
    output logic        song_done,
    output logic        audio_out
);

    localparam int unsigned   TICKS     = CLK_HZ / BEAT_HZ;
    localparam int unsigned   TW        = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
    localparam logic [7:0]    BEAT_LAST = 8'(SONG_LEN - 1);
    localparam logic [33:0]   CLK34     = 34'(CLK_HZ);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    beat_q, beat_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [32:0]   acc_q, acc_d;
    logic          audio_q, audio_d;
    logic          done_q, done_d;
    logic          playing_q;
    logic          tone_ok;
    logic [33:0]   sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            tick_q    <= '0;
            acc_q     <= '0;
            audio_q   <= 1'b0;
            done_q    <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            tick_q    <= tick_d;
            acc_q     <= acc_d;
            audio_q   <= audio_d;
            done_q    <= done_d;
            playing_q <= (state_d == StPlay);
        end
    end

    // Command priority stop > pause > play; play while already playing must not stall the tick.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = StIdle;
            beat_d  = '0;
            tick_d  = '0;
        end else if (pause) begin
            if (state_q == StPlay) begin
                state_d = StPause;
            end
        end else if (play && state_q != StPlay) begin
            state_d = StPlay;
            if (state_q != StPause) begin
                beat_d = '0;
                tick_d = '0;
            end
        end else if (state_q == StPlay) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                if (beat_q < BEAT_LAST) begin
                    beat_d = beat_q + 8'd1;
                end else begin
                    done_d = 1'b1;
                    if (loop_en) begin
                        beat_d = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    assign tone_ok = (tone_in < MUTE_TONE) && (tone_in != '0);
    assign sum     = {1'b0, acc_q} + {1'b0, tone_in, 1'b0};

    // Accumulate 2*f per cycle and toggle on each CLK_HZ overflow: output averages f Hz.
    always_comb begin
        acc_d   = '0;
        audio_d = 1'b0;
        if (!stop && state_q == StPlay && tone_ok) begin
            if (sum >= CLK34) begin
                acc_d   = 33'(sum - CLK34);
                audio_d = ~audio_q;
            end else begin
                acc_d   = sum[32:0];
                audio_d = audio_q;
            end
        end
    end

    assign beat_num  = beat_q;
    assign state     = state_q;
    assign playing   = playing_q;
    assign song_done = done_q;
    assign audio_out = audio_q;

endmodule
